// File: rtl/psum_accum_pkg.sv
// Shared sizing constants and FSM encoding for the psum accumulator and its bench.
package psum_accum_pkg;
    localparam int col      = 8;
    localparam int psum_bw  = 16;
    localparam int len_kij  = 9;
    localparam int len_onij = 16;

    typedef enum logic [1:0] {
        s_idle  = 2'd0,
        s_accum = 2'd1,
        s_drain = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/psum_accum_if.sv
// Input psum stream and output ReLU stream, both valid/ready.
interface psum_accum_if #(
    parameter int col     = psum_accum_pkg::col,
    parameter int psum_bw = psum_accum_pkg::psum_bw
);
    logic                   in_valid;
    logic                   in_ready;
    logic [col*psum_bw-1:0] in_psum;
    logic                   out_valid;
    logic                   out_ready;
    logic [col*psum_bw-1:0] out_data;

    modport master (
        output in_valid, in_psum, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_psum, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/psum_sat_add.sv
// Combinational signed adder that clamps to the representable psum range.
module psum_sat_add #(
    parameter int psum_bw = 16
) (
    input  logic signed [psum_bw-1:0] a,
    input  logic signed [psum_bw-1:0] b,
    output logic signed [psum_bw-1:0] sum
);
    localparam logic [psum_bw-1:0] max_v = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] min_v = {1'b1, {(psum_bw-1){1'b0}}};

    logic [psum_bw:0] wide;

    always_comb begin
        wide = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        // Top two bits disagree only on overflow; the top bit gives the direction.
        if (wide[psum_bw] != wide[psum_bw-1]) begin
            sum = wide[psum_bw] ? min_v : max_v;
        end else begin
            sum = wide[psum_bw-1:0];
        end
    end
endmodule

// File: rtl/psum_accum.sv
// Accumulates len_kij psum vectors per output pixel, then drains them through ReLU.
//   state   | meaning
//   s_idle  | waiting for start
//   s_accum | accepting psum vectors, onij fastest then kij
//   s_drain | emitting ReLU'd acc_mem in onij order
module psum_accum #(
    parameter int col      = psum_accum_pkg::col,
    parameter int psum_bw  = psum_accum_pkg::psum_bw,
    parameter int len_kij  = psum_accum_pkg::len_kij,
    parameter int len_onij = psum_accum_pkg::len_onij
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    psum_accum_if.slave       bus
);
    import psum_accum_pkg::*;

    localparam int vw     = col * psum_bw;
    localparam int kij_w  = cnt_w(len_kij);
    localparam int onij_w = cnt_w(len_onij);
    localparam logic [kij_w-1:0]  kij_last  = kij_w'(len_kij - 1);
    localparam logic [onij_w-1:0] onij_last = onij_w'(len_onij - 1);

    state_t              state, state_nxt;
    logic [kij_w-1:0]    kij;
    logic [onij_w-1:0]   onij;
    logic [onij_w-1:0]   rd_idx;
    logic [vw-1:0]       acc_mem [len_onij];
    logic [vw-1:0]       acc_rd, acc_drain, sum_vec, wr_vec, relu_vec;
    logic                in_hs, out_hs, in_last, out_last;

    assign bus.in_ready = (state == s_accum);
    assign busy         = (state != s_idle);
    assign in_hs        = bus.in_valid && bus.in_ready;
    assign out_hs       = bus.out_valid && bus.out_ready;
    assign in_last      = in_hs && (kij == kij_last) && (onij == onij_last);
    assign out_last     = out_hs && (onij == onij_last);

    // While an output is presented, prefetch the next entry so handshakes run back to back.
    assign rd_idx    = (bus.out_valid && (onij != onij_last)) ? onij + 1'b1 : onij;
    assign acc_rd    = acc_mem[onij];
    assign acc_drain = acc_mem[rd_idx];
    assign wr_vec    = (kij == '0) ? bus.in_psum : sum_vec;

    for (genvar c = 0; c < col; c++) begin : g_lane
        psum_sat_add #(.psum_bw(psum_bw)) u_add (
            .a   (acc_rd[c*psum_bw +: psum_bw]),
            .b   (bus.in_psum[c*psum_bw +: psum_bw]),
            .sum (sum_vec[c*psum_bw +: psum_bw])
        );
        assign relu_vec[c*psum_bw +: psum_bw] =
            acc_drain[c*psum_bw + psum_bw - 1] ? '0 : acc_drain[c*psum_bw +: psum_bw];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            s_idle:  if (start)    state_nxt = s_accum;
            s_accum: if (in_last)  state_nxt = s_drain;
            s_drain: if (out_last) state_nxt = s_idle;
            default:               state_nxt = s_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= s_idle;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kij           <= '0;
            onij          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_hs) begin
                if (onij == onij_last) begin
                    onij <= '0;
                    kij  <= (kij == kij_last) ? '0 : kij + 1'b1;
                end else begin
                    onij <= onij + 1'b1;
                end
            end
            if (state == s_drain) begin
                if (!bus.out_valid) begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= relu_vec;
                end else if (out_hs) begin
                    if (onij == onij_last) begin
                        bus.out_valid <= 1'b0;
                        onij          <= '0;
                        done          <= 1'b1;
                    end else begin
                        onij         <= onij + 1'b1;
                        bus.out_data <= relu_vec;
                    end
                end
            end
        end
    end

    // No reset: the kij = 0 pass overwrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (!reset && in_hs) acc_mem[onij] <= wr_vec;
    end
endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: accumulate, saturate, ReLU, stalls, resets.
module tb_psum_accum;
    import psum_accum_pkg::*;

    localparam int vw = col * psum_bw;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    int checks   = 0;
    int failures = 0;

    psum_accum_if #(.col(col), .psum_bw(psum_bw)) bus ();

    psum_accum #(
        .col(col), .psum_bw(psum_bw), .len_kij(len_kij), .len_onij(len_onij)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [vw-1:0] obs, input logic [vw-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [vw-1:0] splat(input int v);
        logic [vw-1:0] r;
        for (int c = 0; c < col; c++) r[c*psum_bw +: psum_bw] = psum_bw'(v);
        return r;
    endfunction

    function automatic logic [vw-1:0] set_lane(input logic [vw-1:0] v, input int c, input int x);
        v[c*psum_bw +: psum_bw] = psum_bw'(x);
        return v;
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_bit("start_busy", busy, 1'b1);
        check_bit("start_in_ready", bus.in_ready, 1'b1);
    endtask

    // v0 at kij 0, v1 at kij 1, vr afterwards; tag7 puts onij into the top lane.
    task automatic feed(input logic [vw-1:0] v0, input logic [vw-1:0] v1, input logic [vw-1:0] vr,
                        input bit tag7, input bit gaps, input int stop_at, input int start_at);
        int n = 0;
        logic [vw-1:0] vec;
        for (int k = 0; k < len_kij; k++) begin
            for (int o = 0; o < len_onij; o++) begin
                if (n == stop_at) begin
                    bus.in_valid = 1'b0;
                    return;
                end
                vec = (k == 0) ? v0 : (k == 1) ? v1 : vr;
                if (tag7) vec = set_lane(vec, col - 1, o);
                if (gaps && (n % 5 == 2)) begin
                    bus.in_valid = 1'b0;
                    bus.in_psum  = ~vec;
                    tick();
                end
                bus.in_valid = 1'b1;
                bus.in_psum  = vec;
                start        = (n == start_at);
                check_bit("feed_ready", bus.in_ready, 1'b1);
                tick();
                start = 1'b0;
                n++;
            end
        end
        bus.in_valid = 1'b0;
        check_bit("accum_exit_ready", bus.in_ready, 1'b0);
        check_bit("drain_entry_valid", bus.out_valid, 1'b0);
        check_bit("drain_entry_busy", busy, 1'b1);
    endtask

    task automatic drain(input logic [vw-1:0] exp, input bit tag7, input bit toggle);
        int got = 0;
        int cyc = 0;
        bit rdy = 1'b1;
        bit stalled = 1'b0;
        logic [vw-1:0] held;
        logic [vw-1:0] e;
        // Junk on the input and a stray start must both be ignored while draining.
        bus.in_valid = 1'b1;
        bus.in_psum  = splat(-1234);
        start        = 1'b1;
        while (got < len_onij && cyc < 400) begin
            bus.out_ready = toggle ? rdy : 1'b1;
            if (cyc == 1) check_bit("first_out_valid", bus.out_valid, 1'b1);
            if (stalled) begin
                check_bit("stall_valid", bus.out_valid, 1'b1);
                check_vec("stall_data", bus.out_data, held);
            end
            stalled = 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    e = exp;
                    if (tag7) e = set_lane(e, col - 1, len_kij * got);
                    check_vec("drain_data", bus.out_data, e);
                    got++;
                end else begin
                    stalled = 1'b1;
                    held    = bus.out_data;
                end
            end
            check_bit("done_low", done, 1'b0);
            rdy = ~rdy;
            tick();
            cyc++;
        end
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_int("drain_count", got, len_onij);
        check_bit("done_pulse", done, 1'b1);
        check_bit("idle_busy", busy, 1'b0);
        check_bit("idle_out_valid", bus.out_valid, 1'b0);
        tick();
        check_bit("done_cleared", done, 1'b0);
        check_bit("no_extra_valid", bus.out_valid, 1'b0);
    endtask

    initial begin
        logic [vw-1:0] v, v1, vr, e;

        bus.in_valid  = 1'b0;
        bus.in_psum   = '0;
        bus.out_ready = 1'b0;

        reset = 1'b1;
        repeat (3) tick();
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_in_ready", bus.in_ready, 1'b0);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check_vec("rst_out_data", bus.out_data, '0);
        reset = 1'b0;
        tick();

        // in_valid in IDLE must not disturb anything
        bus.in_valid = 1'b1;
        bus.in_psum  = splat(777);
        repeat (4) tick();
        bus.in_valid = 1'b0;
        check_bit("idle_valid_busy", busy, 1'b0);
        check_bit("idle_valid_ready", bus.in_ready, 1'b0);

        // all ones, onij tag in the top lane
        do_start();
        feed(splat(1), splat(1), splat(1), 1'b1, 1'b0, -1, -1);
        drain(splat(9), 1'b1, 1'b0);

        // lane 0 saturates high, with input gaps
        v = set_lane(splat(0), 0, 20000);
        do_start();
        feed(v, v, v, 1'b0, 1'b1, -1, -1);
        drain(set_lane(splat(0), 0, 32767), 1'b0, 1'b0);

        // negative lane clamps to zero by ReLU, start mid-ACCUM ignored
        v = set_lane(splat(2), 3, -5);
        do_start();
        feed(v, v, v, 1'b0, 1'b0, -1, 30);
        drain(set_lane(splat(18), 3, 0), 1'b0, 1'b0);

        // alternating out_ready
        do_start();
        feed(splat(1), splat(1), splat(1), 1'b1, 1'b0, -1, -1);
        drain(splat(9), 1'b1, 1'b1);

        // reset at kij = 4, onij = 7, together with start
        do_start();
        feed(splat(5), splat(5), splat(5), 1'b0, 1'b0, 4 * len_onij + 7, -1);
        check_bit("mid_busy", busy, 1'b1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_in_ready", bus.in_ready, 1'b0);
        check_bit("midrst_out_valid", bus.out_valid, 1'b0);
        check_vec("midrst_out_data", bus.out_data, '0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check_bit("post_rst_idle", busy, 1'b0);
        do_start();
        feed(splat(1), splat(1), splat(1), 1'b1, 1'b0, -1, -1);
        drain(splat(9), 1'b1, 1'b0);

        // two passes k then 2k: second result depends only on its own data
        v = '0;
        e = '0;
        for (int c = 0; c < col; c++) begin
            v = set_lane(v, c, 100 * (c + 1));
            e = set_lane(e, c, 900 * (c + 1));
        end
        do_start();
        feed(v, v, v, 1'b0, 1'b0, -1, -1);
        drain(e, 1'b0, 1'b0);
        for (int c = 0; c < col; c++) begin
            v = set_lane(v, c, 200 * (c + 1));
            e = set_lane(e, c, 1800 * (c + 1));
        end
        do_start();
        feed(v, v, v, 1'b0, 1'b0, -1, -1);
        drain(e, 1'b0, 1'b0);

        // clamp at both rails then walk back inside the range
        v  = set_lane(set_lane(set_lane(splat(0), 0, -30000), 1, 30000), 2, -100);
        v1 = set_lane(set_lane(set_lane(splat(0), 0, -30000), 1, 30000), 2, 50);
        vr = set_lane(set_lane(set_lane(splat(0), 0, 5000), 1, -4000), 2, 50);
        e  = set_lane(set_lane(set_lane(splat(0), 0, 2232), 1, 4767), 2, 300);
        do_start();
        feed(v, v1, vr, 1'b0, 1'b1, -1, -1);
        drain(e, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
